// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: word width, opcode field
// position and the FSM state encoding.
package instr_sequencer_pkg;

    localparam int unsigned IW = 26;

    // Opcode field inside an instruction word
    localparam int unsigned OpMsb = 25;
    localparam int unsigned OpLsb = 23;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStepWait = 2'd2,
        StDone     = 2'd3
    } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Control and issue bus of the instruction sequencer. The master side loads
// and starts programs and accepts words; the slave side is the sequencer.
interface instr_sequencer_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned IW = 26
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          step_mode;
    logic          step;
    logic          abort;
    logic          instr_ready;
    logic          instr_valid;
    logic [IW-1:0] instruction;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;

    modport master (
        output load_en, load_addr, load_data, prog_len, start, step_mode, step, abort,
               instr_ready,
        input  instr_valid, instruction, pc, busy, done
    );

    modport slave (
        input  load_en, load_addr, load_data, prog_len, start, step_mode, step, abort,
               instr_ready,
        output instr_valid, instruction, pc, busy, done
    );
endinterface

// File: rtl/instr_sequencer_store.sv
// Program store: DEPTH x IW register array, synchronous write, asynchronous
// read. Contents are deliberately not reset.
module instr_sequencer_store #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned IW    = 26
) (
    input  logic          clock,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [IW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [IW-1:0] o_rd_data
);
    logic [IW-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: steps a program counter through the program store and
// issues one word per valid/ready transfer, in free-run or single-step mode.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input logic              clock,
    input logic              reset_n,
    instr_sequencer_if.slave bus
);
    seq_state_e    r_state;
    logic [AW-1:0] r_pc;
    logic [IW-1:0] r_instr;
    logic          r_valid;
    logic          r_done;
    logic          r_mode;
    logic [AW:0]   r_len;

    logic          w_idle_like;
    logic          w_wr_en;
    logic          w_xfer;
    logic          w_last;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_rd_addr;
    logic [IW-1:0] w_rd_data;

    // Loads only land while no program is being issued
    assign w_idle_like = (r_state == StIdle) || (r_state == StDone);
    assign w_wr_en     = w_idle_like && bus.load_en;
    assign w_xfer      = r_valid && bus.instr_ready;
    assign w_pc_inc    = r_pc + AW'(1);
    assign w_last      = ({1'b0, r_pc} == (r_len - (AW + 1)'(1)));

    // Read address: word 0 on start, pc+1 for back-to-back issue, pc on step release
    always_comb begin
        w_rd_addr = '0;
        case (r_state)
            StRun:      w_rd_addr = w_pc_inc;
            StStepWait: w_rd_addr = r_pc;
            default:    w_rd_addr = '0;
        endcase
    end

    instr_sequencer_store #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_store (
        .clock     (clock),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.load_addr),
        .i_wr_data (bus.load_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Sequencer FSM with registered issue outputs; abort overrides everything
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_mode  <= 1'b0;
            r_len   <= '0;
        end else if (bus.abort) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                StIdle, StDone: begin
                    // A load in the same cycle as start wins; start is dropped
                    if (!bus.load_en && bus.start) begin
                        if (bus.prog_len == '0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_len  <= bus.prog_len;
                            r_mode <= bus.step_mode;
                            r_pc   <= '0;
                            r_done <= 1'b0;
                            if (!bus.step_mode) begin
                                r_instr <= w_rd_data;
                                r_valid <= 1'b1;
                                r_state <= StRun;
                            end else begin
                                r_valid <= 1'b0;
                                r_state <= StStepWait;
                            end
                        end
                    end
                end
                StRun: begin
                    // Without a handshake everything holds
                    if (w_xfer) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else if (!r_mode) begin
                            r_pc    <= w_pc_inc;
                            r_instr <= w_rd_data;
                        end else begin
                            r_pc    <= w_pc_inc;
                            r_valid <= 1'b0;
                            r_state <= StStepWait;
                        end
                    end
                end
                StStepWait: begin
                    if (bus.step) begin
                        r_instr <= w_rd_data;
                        r_valid <= 1'b1;
                        r_state <= StRun;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.instr_valid = r_valid;
    assign bus.instruction = r_instr;
    assign bus.pc          = r_pc;
    assign bus.busy        = (r_state == StRun) || (r_state == StStepWait);
    assign bus.done        = r_done;

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream instruction-issue stage for the 8-bit ALU/register-file datapath.
- Holds a small loadable program store of 26-bit instruction words.
- Steps a program counter through that store and presents one word per transfer on a valid/ready handshake; the downstream stage consumes the word as its instruction input.
- Supports free-run and single-step modes, plus abort.

Parameters:
- DEPTH, 16: number of instruction words in the program store.
- AW, 4: address width; DEPTH = 2**AW.
- IW, 26: instruction word width.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  write load_data into the store at load_addr.
- load_addr  in  AW  store write address.
- load_data  in  IW  store write data.
- prog_len  in  AW+1  number of words to issue (0..DEPTH); sampled on start.
- start  in  1  begin issuing from address 0.
- step_mode  in  1  sampled on start: 0 = free-run, 1 = single-step.
- step  in  1  single-step release pulse.
- abort  in  1  terminate the program immediately.
- instr_ready  in  1  downstream can accept the word this cycle.
- instr_valid  out  1  instruction holds a word to transfer.
- instruction  out  IW  registered instruction word.
- pc  out  AW  address of the word currently presented.
- busy  out  1  high in RUN and STEP_WAIT.
- done  out  1  high in DONE; stays high until the next start.

Behaviour:
Reset (async, reset_n=0):
- state=IDLE; pc=0; instruction=0; instr_valid=0; busy=0; done=0; len_q=0; mode_q=0.
- The store contents are not reset.

Store:
- DEPTH x IW register array with asynchronous read and synchronous write.
- Writes are accepted only when state is IDLE or DONE; load_en is ignored in RUN and STEP_WAIT.

States: IDLE, RUN, STEP_WAIT, DONE.
- IDLE/DONE + load_en: the store is written. A start in the same cycle is ignored (load wins).
- IDLE/DONE + start with prog_len=0: go to DONE (done=1, no issue).
- IDLE/DONE + start with prog_len>0:
  - Latch len_q=prog_len, mode_q=step_mode; pc=0; done=0.
  - Free-run: instruction<=mem[0], instr_valid=1 next cycle, state RUN. Latency from start to valid is 1 cycle.
  - Step mode: state STEP_WAIT, instr_valid=0.
- RUN, instr_valid & !instr_ready: instruction, pc and instr_valid hold stable (no change allowed while stalled).
- RUN, handshake (valid & ready):
  - If pc==len_q-1: instr_valid=0, state DONE, done=1 next cycle.
  - Else if mode_q=0: pc<=pc+1, instruction<=mem[pc+1], valid stays 1. Throughput is 1 word/cycle back-to-back.
  - Else (mode_q=1): pc<=pc+1, instr_valid=0, state STEP_WAIT.
- STEP_WAIT + step: instruction<=mem[pc], instr_valid=1, state RUN. step in any other state is ignored.
- abort (any state, synchronous):
  - state=IDLE, instr_valid=0, pc=0, done=0.
  - abort has priority over the handshake, start and step.
- len_q=DEPTH: pc reaches DEPTH-1 and finishes. pc never wraps while issuing.
- start while busy is ignored.
- Reset mid-program: all outputs immediately take their reset values; the word in flight is lost.
- busy = (state==RUN)|(state==STEP_WAIT).
- instruction keeps its last value after DONE or abort; instr_valid=0 qualifies it.

Decomposition:
- Shared package (alu_pkg):
  - IW=26.
  - Opcode field position [25:23].
  - State encoding constants IDLE=2'd0, RUN=2'd1, STEP_WAIT=2'd2, DONE=2'd3.
- One sub-module is natural: instr_store (the DEPTH x IW array, synchronous write, asynchronous read).
- The FSM, pc and output register stay in instr_sequencer.

Test Plan:
- Load 4 words 0x0000001..0x0000004, prog_len=4, step_mode=0, start, instr_ready=1 -> valid 1 cycle after start; words 1,2,3,4 on 4 consecutive cycles with pc 0..3; done=1 the cycle after the 4th transfer; busy low.
- Same program with instr_ready low for 3 cycles at pc=1 -> instruction=0x0000002 and pc=1 held stable for all 3 cycles; no word skipped or duplicated.
- step_mode=1, prog_len=3 -> valid stays 0 until each step pulse; exactly one word per step; done after the 3rd transfer; extra step in DONE has no effect.
- prog_len=0 start -> DONE next cycle, instr_valid never asserted. prog_len=16 -> 16 words, pc ends at 15, no wrap.
- abort at pc=2 while stalled -> next cycle state IDLE, instr_valid=0, pc=0, done=0. load_en during RUN -> store unchanged (re-run issues the original words).
- reset_n pulsed low asynchronously mid-RUN -> outputs drop to reset values without waiting for a clock edge. start together with load_en in DONE -> write happens, no issue starts.
